// File: rtl/microwave_countdown_timer.sv
// BCD mm:ss countdown core: keypad load, per-second countdown, door/pause control, done flag.
// Optional macro DONE_HOLD_EN: done is held in DONE until stop_clear or door open (default: 1-clk pulse).
module microwave_countdown_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  output logic [15:0] count,
  output logic        mag_on,
  output logic        done,
  output logic [1:0]  state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        st;
  state_t        nxt_st;
  logic [PW-1:0] presc;
  logic [PW-1:0] nxt_presc;
  logic [15:0]   nxt_count;
  logic [15:0]   dec_count;
  logic          tick;

  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Keypad entry may hold any nibble; force it into a legal mm:ss value.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] d);
    return {sat_digit(d[15:12], 4'd9), sat_digit(d[11:8], 4'd9),
            sat_digit(d[7:4], 4'd5), sat_digit(d[3:0], 4'd9)};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick      = (presc == PMAX);
  assign dec_count = bcd_dec(count);

  always_comb begin
    nxt_st    = st;
    nxt_count = count;
    nxt_presc = presc;
    case (st)
      IDLE: begin
        if (!stop_clear) begin
          if (start) begin
            if (door_closed && (count != 16'h0000)) begin
              nxt_st    = RUN;
              nxt_presc = '0;
            end
          end else if (load) begin
            nxt_count = clamp_bcd(din);
          end
        end
      end
      RUN: begin
        // A tick landing on a pause is deferred: prescaler stays at PMAX.
        if (stop_clear || !door_closed) begin
          nxt_st = PAUSE;
        end else if (tick) begin
          nxt_presc = '0;
          nxt_count = dec_count;
          if (dec_count == 16'h0000) nxt_st = DONE;
        end else begin
          nxt_presc = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          nxt_st    = IDLE;
          nxt_count = '0;
          nxt_presc = '0;
        end else if (start && door_closed) begin
          nxt_st = RUN;
        end
      end
      DONE: begin
        nxt_count = '0;
`ifdef DONE_HOLD_EN
        if (stop_clear || !door_closed) nxt_st = IDLE;
`else
        nxt_st = IDLE;
`endif
      end
      default: nxt_st = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      count  <= '0;
      presc  <= '0;
      mag_on <= 1'b0;
      done   <= 1'b0;
    end else begin
      st     <= nxt_st;
      count  <= nxt_count;
      presc  <= nxt_presc;
      mag_on <= (nxt_st == RUN);
      done   <= (nxt_st == DONE);
    end
  end

  assign state = st;

endmodule
